schoolbook_radix: RTL and testbench

//  Parametrised iterative schoolbook multiplier: c = a * b, unsigned, full-width product.

---
 rtl/schoolbook_radix.sv | 86 ++++++++
 tb/tb_schoolbook_radix.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/schoolbook_radix.sv
// Iterative radix-2^DIGIT schoolbook multiplier, c = a * b (unsigned, full width).
// Optional early termination on zero upper digits: define SCHOOLBOOK_SKIPZERO_EN.
module schoolbook_radix #(
    parameter int N_A   = 521,
    parameter int N_B   = 521,
    parameter int DIGIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_A-1:0]     a,
    input  logic [N_B-1:0]     b,
    output logic               ready,
    output logic               done,
    output logic [N_A+N_B-1:0] c
);

    localparam int NDIG = (N_B + DIGIT - 1) / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam int BW   = NDIG * DIGIT;
    localparam int PW   = N_A + N_B;

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   a_sh;
    logic [BW-1:0]   b_r;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   term;
    logic [PW-1:0]   sum;
    logic            last;

    // a is pre-shifted and b consumed from the bottom, replacing the variable
    // shifts by cnt*DIGIT. Each term a*digit*2^(cnt*DIGIT) is bounded by a*b,
    // so truncating a_sh and the term to N_A+N_B bits is exact.
    always_comb begin
        term = a_sh * PW'(b_r[DIGIT-1:0]);
        sum  = acc + term;
`ifdef SCHOOLBOOK_SKIPZERO_EN
        last = (cnt == CW'(NDIG - 1)) || ((b_r >> DIGIT) == '0);
`else
        last = (cnt == CW'(NDIG - 1));
`endif
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            a_sh  <= '0;
            b_r   <= '0;
            cnt   <= '0;
            c     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= PW'(a);
                        b_r   <= BW'(b);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc  <= sum;
                    a_sh <= a_sh << DIGIT;
                    b_r  <= b_r >> DIGIT;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        c     <= sum;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_schoolbook_radix.sv
// Directed bench for schoolbook_radix: default 521x521/8 instance plus
// small DIGIT=7, DIGIT=1 and single-cycle DIGIT=N_B instances.
module tb_schoolbook_radix;

`ifdef SCHOOLBOOK_SKIPZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [520:0]  a = '0;
    logic [520:0]  b = '0;
    logic          ready;
    logic          done;
    logic [1041:0] c;

    logic          sstart = 1'b0;
    logic [19:0]   a7 = '0, b7 = '0;
    logic          ready7, done7;
    logic [39:0]   c7;
    logic [7:0]    a1 = '0, b1 = '0;
    logic          ready1, done1;
    logic [15:0]   c1;
    logic [63:0]   a32 = '0;
    logic [31:0]   b32 = '0;
    logic          ready32, done32;
    logic [95:0]   c32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    schoolbook_radix #(.N_A(521), .N_B(521), .DIGIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .c(c));

    schoolbook_radix #(.N_A(20), .N_B(20), .DIGIT(7)) dut7 (
        .clk(clk), .rst(rst), .start(sstart), .a(a7), .b(b7),
        .ready(ready7), .done(done7), .c(c7));

    schoolbook_radix #(.N_A(8), .N_B(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(sstart), .a(a1), .b(b1),
        .ready(ready1), .done(done1), .c(c1));

    schoolbook_radix #(.N_A(64), .N_B(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst(rst), .start(sstart), .a(a32), .b(b32),
        .ready(ready32), .done(done32), .c(c32));

    task automatic check(input string tag, input logic [1041:0] got, input logic [1041:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h..%h want=%h..%h", tag,
                     got[1041:946], got[95:0], want[1041:946], want[95:0]);
        end
    endtask

    // Expected cycles from accept edge to done.
    function automatic int exp_lat(input logic [520:0] bv, input int ndig, input int d);
        int hi = 1;
        for (int k = 0; k < ndig; k++)
            if ((bv >> (k * d)) != '0) hi = k + 1;
        return SKIP ? hi : ndig;
    endfunction

    task automatic launch(input logic [520:0] av, input logic [520:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int ready_hi);
        cyc = 0;
        ready_hi = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1 && ready === 1'b1) ready_hi++;
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rh, n;
        logic [1041:0] w;
        logic [520:0] ra, rb;

        #12;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_c", c, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: basic product and latency
        launch(3, 5);
        check("s1_ready_low", ready, 0);
        wait_done(200, lat, rh);
        check("s1_latency", lat, exp_lat(5, 66, 8));
        check("s1_c", c, 15);
        check("s1_ready_in_done", ready, 1);
        check("s1_ready_busy", rh, 0);
        @(negedge clk);
        check("s1_done_pulse", done, 0);
        check("s1_c_held", c, 15);

        // 2: all-ones and top-digit padding
        launch('1, '1);
        wait_done(200, lat, rh);
        w = '0;
        w = w - (1042'd1 << 522) + 1042'd1;
        check("s2_ones_c", c, w);
        check("s2_ones_lat", lat, 66);
        launch(521'd1 << 520, 521'd1 << 520);
        wait_done(200, lat, rh);
        check("s2_pow_c", c, 1042'd1 << 1040);
        check("s2_pow_lat", lat, 66);

        // 3: start while busy is ignored
        launch(7, 9);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                a = 1; b = 1; start = 1'b1;
            end else if (lat == 11) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("s3_lat", lat, exp_lat(9, 66, 8));
        check("s3_c", c, 63);
        count_dones(80, n);
        check("s3_extra_done", n, 0);
        check("s3_c_kept", c, 63);

        // 4: back-to-back start in the done cycle
        launch(7, 9);
        wait_done(200, lat, rh);
        check("s4_c1", c, 63);
        launch(11, 13);
        check("s4_accepted", ready, 0);
        check("s4_c_hold", c, 63);
        wait_done(200, lat, rh);
        check("s4_lat2", lat, exp_lat(13, 66, 8));
        check("s4_c2", c, 143);

        // 5: reset mid-operation
        launch(5, 521'd1 << 520);
        for (int i = 0; i < 30; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("s5_rst_c", c, 0);
        check("s5_rst_done", done, 0);
        check("s5_rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b1;
        count_dones(80, n);
        check("s5_no_done", n, 0);
        launch(2, 2);
        wait_done(200, lat, rh);
        check("s5_next_c", c, 4);

        // 6: zero upper digits
        launch(521'h1234, 521'h1FF);
        wait_done(200, lat, rh);
        check("s6_c", c, 1042'h2455CC);
        check("s6_lat", lat, SKIP ? 2 : 66);
        launch(521'h1234, 0);
        wait_done(200, lat, rh);
        check("s6_zero_c", c, 0);
        check("s6_zero_lat", lat, SKIP ? 1 : 66);

        // random operands against a*b
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 17; j++) begin
                ra[j*32 +: 9] = 9'($urandom);
                if (j < 16) ra[j*32 + 9 +: 23] = 23'($urandom);
                rb[j*32 +: 9] = 9'($urandom);
                if (j < 16) rb[j*32 + 9 +: 23] = 23'($urandom);
            end
            launch(ra, rb);
            wait_done(200, lat, rh);
            check("rand_c", c, 1042'(ra) * 1042'(rb));
            check("rand_lat", lat, exp_lat(rb, 66, 8));
        end

        // small configurations: DIGIT=7 (non-divisor), DIGIT=1, DIGIT=N_B
        for (int t = 0; t < 6; t++) begin
            int l7, l1, l32;
            if (t == 0) begin
                a7 = '1; b7 = '1; a1 = '1; b1 = '1; a32 = '1; b32 = '1;
            end else if (t == 1) begin
                a7 = 20'd3; b7 = 20'd5; a1 = 8'd7; b1 = 8'd9; a32 = 64'd11; b32 = 32'd0;
            end else begin
                a7 = 20'($urandom); b7 = 20'($urandom);
                a1 = 8'($urandom);  b1 = 8'($urandom);
                a32 = {$urandom, $urandom}; b32 = $urandom;
            end
            sstart = 1'b1;
            @(negedge clk);
            sstart = 1'b0;
            l7 = 0; l1 = 0; l32 = 0;
            for (int cyc = 1; cyc <= 12; cyc++) begin
                @(negedge clk);
                if (done7 === 1'b1 && l7 == 0) l7 = cyc;
                if (done1 === 1'b1 && l1 == 0) l1 = cyc;
                if (done32 === 1'b1 && l32 == 0) l32 = cyc;
            end
            check("d7_c", c7, 40'(a7) * 40'(b7));
            check("d7_lat", l7, exp_lat(521'(b7), 3, 7));
            check("d1_c", c1, 16'(a1) * 16'(b1));
            check("d1_lat", l1, exp_lat(521'(b1), 8, 1));
            check("d32_c", c32, 96'(a32) * 96'(b32));
            check("d32_lat", l32, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
